// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by instr_mem, the core decoder and the
// instruction fetch arbiter.
//   WIDTH_IN   default instruction address width
//   WIDTH_OUT  default instruction word width
//   OPCODE_W   opcode field width; the opcode sits in the top OPCODE_W bits
//              of an instruction word, i.e. [width_out-1 -: OPCODE_W]
//   opcode_t   opcode constants (nop, endop)
package proc_pkg;

  localparam int unsigned WIDTH_IN  = 12;
  localparam int unsigned WIDTH_OUT = 17;
  localparam int unsigned OPCODE_W  = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP   = 5'd28,
    OP_ENDOP = 5'd31
  } opcode_t;

  function automatic logic is_endop(input logic [OPCODE_W-1:0] op);
    return op == OP_ENDOP;
  endfunction

endpackage

// File: rtl/fetch_rr_pick.sv
// fetch_rr_pick: combinational cyclic first-one finder.
//   eligible  in   n      request mask
//   rr_ptr    in   idx_w  index where the search starts
//   winner    out  idx_w  first set index at or after rr_ptr (wrapping)
//   found     out  1      at least one eligible bit was set
module fetch_rr_pick #(
  parameter int unsigned n     = 4,
  parameter int unsigned idx_w = 2
) (
  input  logic [n-1:0]     eligible,
  input  logic [idx_w-1:0] rr_ptr,
  output logic [idx_w-1:0] winner,
  output logic             found
);

  int unsigned       idx;
  logic [idx_w-1:0]  sel;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 0; k < n; k++) begin
      idx = (32'(rr_ptr) + k) % n;
      sel = idx_w'(idx);
      if (!found && eligible[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// instr_fetch_arbiter: shares the single read port of instr_mem between
// n_cores near-lockstep cores. One fetch address is granted per cycle with
// round-robin priority; every other eligible core presenting the same
// address rides along on that grant. The registered memory word (1-cycle
// latency) is routed back two cycles after the grant.
//   clk, rst     clock, synchronous active-high reset
//   core_en      per-core participation enable
//   core_req     per-core fetch request, held until that core's core_valid
//   core_addr    flat per-core fetch addresses
//   core_instr   flat per-core last delivered instruction
//   core_valid   per-core one-cycle delivery pulse
//   core_done    per-core sticky "endop received"
//   done_all     every enabled core done (and at least one enabled)
//   mem_addr     to instr_mem.addr1
//   mem_data     from instr_mem.instr_out
module instr_fetch_arbiter
  import proc_pkg::*;
#(
  parameter int unsigned n_cores   = 4,
  parameter int unsigned width_in  = WIDTH_IN,
  parameter int unsigned width_out = WIDTH_OUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [n_cores-1:0]            core_en,
  input  logic [n_cores-1:0]            core_req,
  input  logic [n_cores*width_in-1:0]   core_addr,
  output logic [n_cores*width_out-1:0]  core_instr,
  output logic [n_cores-1:0]            core_valid,
  output logic [n_cores-1:0]            core_done,
  output logic                          done_all,
  output logic [width_in-1:0]           mem_addr,
  input  logic [width_out-1:0]          mem_data
);

  localparam int unsigned idx_w = (n_cores > 1) ? $clog2(n_cores) : 1;

  logic [n_cores-1:0]  busy;
  logic [n_cores-1:0]  grant_q;
  logic [n_cores-1:0]  eligible;
  logic [n_cores-1:0]  served;
  logic [idx_w-1:0]    rr_ptr;
  logic [idx_w-1:0]    rr_next;
  logic [idx_w-1:0]    winner;
  logic                found;
  logic [width_in-1:0] win_addr;
  logic [width_in-1:0] last_addr;
  logic                data_endop;

  assign eligible = core_en & core_req & ~busy & ~core_done;

  fetch_rr_pick #(
    .n     (n_cores),
    .idx_w (idx_w)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .found    (found)
  );

  // Broadcast: everyone eligible with the winner's address shares the grant.
  always_comb begin
    win_addr = '0;
    served   = '0;
    for (int unsigned i = 0; i < n_cores; i++) begin
      if (idx_w'(i) == winner)
        win_addr = core_addr[i*width_in +: width_in];
    end
    if (found) begin
      for (int unsigned i = 0; i < n_cores; i++) begin
        served[i] = eligible[i] &&
                    (core_addr[i*width_in +: width_in] == win_addr);
      end
    end
  end

  assign rr_next = (winner == idx_w'(n_cores - 1)) ? '0 : winner + idx_w'(1);

  // Idle cycles keep the previous address on the memory port.
  assign mem_addr = rst ? '0 : (found ? win_addr : last_addr);

  assign data_endop = is_endop(mem_data[width_out-1 -: OPCODE_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      grant_q    <= '0;
      rr_ptr     <= '0;
      last_addr  <= '0;
      core_instr <= '0;
      core_valid <= '0;
      core_done  <= '0;
      done_all   <= 1'b0;
    end else begin
      if (found) begin
        rr_ptr    <= rr_next;
        last_addr <= win_addr;
      end
      // served is empty without a grant, so grant_q clears on idle cycles.
      grant_q <= served;
      // Bits being set (served) are never busy, bits being cleared (grant_q)
      // are always busy, so the two updates never collide.
      busy       <= (busy & ~grant_q) | served;
      core_valid <= grant_q;
      if (data_endop)
        core_done <= core_done | grant_q;
      for (int unsigned i = 0; i < n_cores; i++) begin
        if (grant_q[i])
          core_instr[i*width_out +: width_out] <= mem_data;
      end
      done_all <= (core_en != '0) && ((core_en & ~core_done) == '0);
    end
  end

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
module tb_instr_fetch_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned WI = 12;
  localparam int unsigned WO = 17;
  localparam int NCYC = 3000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     core_en;
  logic [NC-1:0]     core_req;
  logic [NC*WI-1:0]  core_addr;
  logic [NC*WO-1:0]  core_instr;
  logic [NC-1:0]     core_valid;
  logic [NC-1:0]     core_done;
  logic              done_all;
  logic [WI-1:0]     mem_addr;
  logic [WO-1:0]     mem_data;

  logic [WO-1:0] ram [0:(1<<WI)-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state (in terms of deliveries, not RTL registers)
  logic [NC-1:0] m_inflight;
  int            m_due  [NC];
  logic [WO-1:0] m_data [NC];
  logic [WO-1:0] m_instr[NC];
  logic [NC-1:0] m_done;
  int            m_ptr;
  logic [WI-1:0] m_last;
  logic          m_done_all;
  logic [NC-1:0] exp_valid;
  logic [NC-1:0] el;
  logic [WI-1:0] exp_addr;
  logic [WI-1:0] w_addr;
  int            win;

  instr_fetch_arbiter #(
    .n_cores   (NC),
    .width_in  (WI),
    .width_out (WO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_en    (core_en),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_instr (core_instr),
    .core_valid (core_valid),
    .core_done  (core_done),
    .done_all   (done_all),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // instr_mem behaviour: registered read, one cycle latency
  always @(posedge clk) mem_data <= ram[mem_addr];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [WI-1:0] pick_addr();
    if ($urandom_range(0, 79) == 0) return WI'(108);
    return WI'($urandom_range(0, 11));
  endfunction

  function automatic logic [WI-1:0] addr_of(input int i);
    return core_addr[i*WI +: WI];
  endfunction

  initial begin
    for (int a = 0; a < (1 << WI); a++) begin
      ram[a] = WO'($urandom);
      if (ram[a][WO-1 -: 5] == 5'd31) ram[a][WO-1 -: 5] = 5'd28;
    end
    ram[108] = {5'd31, 12'($urandom)};

    rst       = 1'b1;
    core_en   = '1;
    core_req  = '0;
    core_addr = '0;

    m_inflight = '0;
    m_done     = '0;
    m_ptr      = 0;
    m_last     = '0;
    m_done_all = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_due[i]   = 0;
      m_data[i]  = '0;
      m_instr[i] = '0;
    end

    repeat (2) @(posedge clk);

    for (cyc = 0; cyc < NCYC; cyc++) begin
      #1;
      // Deliveries due this cycle: instruction lands two cycles after grant
      exp_valid = '0;
      for (int i = 0; i < NC; i++) begin
        if (m_inflight[i] && m_due[i] == cyc) begin
          exp_valid[i]  = 1'b1;
          m_instr[i]    = m_data[i];
          if (m_data[i][WO-1 -: 5] == 5'd31) m_done[i] = 1'b1;
          m_inflight[i] = 1'b0;
        end
      end
      check("core_valid", 64'(core_valid), 64'(exp_valid));
      check("core_done", 64'(core_done), 64'(m_done));
      check("done_all", 64'(done_all), 64'(m_done_all));
      for (int i = 0; i < NC; i++)
        check($sformatf("core_instr%0d", i), 64'(core_instr[i*WO +: WO]),
              64'(m_instr[i]));

      // Stimulus for this cycle
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) core_en = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        if (!core_req[i] || exp_valid[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            core_req[i] = 1'b1;
            core_addr[i*WI +: WI] = pick_addr();
          end else begin
            core_req[i] = 1'b0;
          end
        end
      end
      #1;

      // Arbitration by rule: cyclic first eligible from pointer, broadcast
      el  = core_en & core_req & ~m_inflight & ~m_done;
      win = -1;
      for (int k = 0; k < NC; k++) begin
        if (win < 0 && el[(m_ptr + k) % NC]) win = (m_ptr + k) % NC;
      end
      w_addr   = (win >= 0) ? addr_of(win) : '0;
      exp_addr = rst ? '0 : ((win >= 0) ? w_addr : m_last);
      check("mem_addr", 64'(mem_addr), 64'(exp_addr));

      if (rst) begin
        m_inflight = '0;
        m_done     = '0;
        m_ptr      = 0;
        m_last     = '0;
        m_done_all = 1'b0;
        for (int i = 0; i < NC; i++) m_instr[i] = '0;
      end else begin
        m_done_all = (core_en != '0) && ((core_en & ~m_done) == '0);
        if (win >= 0) begin
          for (int i = 0; i < NC; i++) begin
            if (el[i] && addr_of(i) == w_addr) begin
              m_inflight[i] = 1'b1;
              m_due[i]      = cyc + 2;
              m_data[i]     = ram[w_addr];
            end
          end
          m_ptr  = (win + 1) % NC;
          m_last = w_addr;
        end
      end

      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_arbiter.md
# instr_fetch_arbiter

Shares the single-read-port instruction memory `instr_mem` between up to `n_cores` processing cores that run the same program in near-lockstep. It grants one fetch address per cycle with round-robin priority, and serves every other requesting core presenting the same address in the same grant (broadcast). It routes the registered memory word back to the granted cores and tracks per-core completion on `endop`. It sits between the cores' fetch stages and `instr_mem.addr1`.

## Interface
- `n_cores`, 4: number of requesting cores (1..8).
- `width_in`, 12: instruction address width (matches `instr_mem` `width_in`).
- `width_out`, 17: instruction width; opcode = bits [width_out-1 -: 5].
- `clk`  in  1: the single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `core_en`  in  n_cores: core participates; disabled cores are never granted.
- `core_req`  in  n_cores: fetch request; held with a stable address until that core's `core_valid`.
- `core_addr`  in  n_cores*width_in: flat; core i address in slice [i*width_in +: width_in].
- `core_instr`  out  n_cores*width_out: flat; last instruction delivered to core i, held until next delivery.
- `core_valid`  out  n_cores: one-cycle pulse, `core_instr` slice i freshly loaded.
- `core_done`  out  n_cores: sticky, core i has received `endop` (opcode 31).
- `done_all`  out  1: every enabled core done and `core_en` != 0.
- `mem_addr`  out  width_in: drives `instr_mem.addr1`.
- `mem_data`  in  width_out: `instr_mem.instr_out`, registered, 1-cycle read latency.

## Operation
- Eligible[i] = `core_en[i]` & `core_req[i]` & ~busy[i] & ~`core_done[i]`.
- Winner: first eligible index at or after `rr_ptr`, searching cyclically. With no eligible core there is no grant, `mem_addr` holds its last value, and nothing is recorded in flight.
- Served mask: the winner plus every eligible core whose address equals the winner's address.
- `mem_addr` = winner's address (combinational), 0 while `rst`.
- On a grant: `rr_ptr` <= (winner+1) mod n_cores; busy |= served; grant_q <= served. With no grant, grant_q <= 0.
- Data stage: for each i in grant_q, `core_instr` slice i <= `mem_data`, `core_valid[i]` <= 1, busy[i] <= 0. If opcode == 31, `core_done[i]` <= 1.
- `core_valid` is 0 for all cores not loaded in that cycle.
- `core_done` clears only on `rst`. A done core's `core_req` is ignored.
- A request seen in the `core_valid` cycle is treated as a new fetch and is arbitrated normally.
- Reset: `core_instr`=0, `core_valid`=0, `core_done`=0, `done_all`=0, busy=0, grant_q=0, `rr_ptr`=0.
- Reset mid-fetch: in-flight grants are discarded. No `core_valid` is issued for them after reset deasserts.
- `core_en[i]` dropped while core i is in flight: the delivery still completes; no new grants to core i.

## Timing
- Cycle c: core i eligible and served; `mem_addr` carries its address; `instr_mem` latches at the end of c.
- Cycle c+1: `mem_data` valid; core i is masked (busy).
- Cycle c+2: `core_valid[i]`=1 and `core_instr` valid. Request-to-valid latency is 2 cycles.
- Throughput: one grant per cycle across all cores. A single core can be served at most once every 2 cycles (request in c+2 is allowed).
- `done_all` is registered: it goes high the cycle after the last enabled `core_done` sets, i.e. in the same cycle as that `core_valid`+1.

## Structure
- Shared package `proc_pkg`: 5-bit opcode constants (`endop`=31, `nop`=28, etc.), the opcode field position, and `width_in`/`width_out` defaults, all shared with `instr_mem` and the core decoder.
- One sub-module: `fetch_rr_pick`, a combinational cyclic first-one finder (inputs eligible mask and `rr_ptr`; outputs winner index and found flag).
- Address comparison, busy/grant registers and per-core output registers live in `instr_fetch_arbiter`.

## Test plan
- Single core: core 0 requests addr 2 at cycle 0 → `mem_addr`=2 in cycle 0, `core_valid[0]` in cycle 2, `core_instr[0]`=ram[2]. No other core gets `core_valid`.
- Broadcast: cores 0–3 all request addr 10 in the same cycle → one grant; all four `core_valid` pulse together 2 cycles later with ram[10]. `rr_ptr` advances to 1.
- Round-robin: cores 0–3 request distinct addrs 5/6/7/8, re-requesting on each valid → grant order 0,1,2,3,0,… one per cycle. No core starves; each core gets a valid every 4 cycles once steady.
- Endop: core 1 fetches addr 108 (`endop`) → `core_done[1]`=1. Its further requests are ignored. `done_all` rises one cycle after the last enabled core's done, with disabled cores ignored.
- Reset mid-fetch: assert `rst` in cycle c+1 of an in-flight grant → no `core_valid` afterwards. All outputs read 0, `mem_addr`=0 during reset, and first grant after reset goes to the lowest eligible index.
- Disabled core: `core_en`=4'b1011 with core 2 requesting → core 2 is never granted and is excluded from `done_all`.
